// File: rtl/pong_match_ctrl_pkg.sv
// Shared types and constants for the pong match sequencer and the playfield.
package pong_match_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SERVE    = 3'd1,
    ST_PLAY     = 3'd2,
    ST_POINT    = 3'd3,
    ST_PAUSE    = 3'd4,
    ST_GAMEOVER = 3'd5
  } state_t;

  // Ball recentre position used by the engine on a serve pulse.
  localparam logic [9:0] BALL_X0 = 10'd320;
  localparam logic [9:0] BALL_Y0 = 10'd240;

  // Geometry shared with the playfield renderer.
  localparam int STICKSIZE = 64;
  localparam int BALLSIZE  = 8;

  // Score value that blanks the digit on the playfield.
  localparam logic [3:0] SCORE_HIDDEN = 4'hF;

  // Steps per frame grow with difficulty: 1 + level/2, so 1..8.
  function automatic logic [3:0] burst_len(input logic [3:0] lvl);
    return 4'd1 + {1'b0, lvl[3:1]};
  endfunction

endpackage

// File: rtl/pong_match_ctrl_if.sv
// Player/engine inputs and renderer/engine outputs of the match sequencer.
interface pong_match_ctrl_if;
  logic       frame_tick;
  logic       start_req;
  logic       pause_btn;
  logic       point_p1;
  logic       point_p2;
  logic       stick_hit;
  logic [3:0] scorep1;
  logic [3:0] scorep2;
  logic [3:0] difflevel;
  logic       serve;
  logic       serve_dir;
  logic       ball_step;
  logic       ball_visible;
  logic       paused;

  modport master (
    output frame_tick, start_req, pause_btn, point_p1, point_p2, stick_hit,
    input  scorep1, scorep2, difflevel, serve, serve_dir, ball_step,
           ball_visible, paused
  );

  modport slave (
    input  frame_tick, start_req, pause_btn, point_p1, point_p2, stick_hit,
    output scorep1, scorep2, difflevel, serve, serve_dir, ball_step,
           ball_visible, paused
  );
endinterface

// File: rtl/pong_match_ctrl_step_burst_gen.sv
// Emits a run of back-to-back ball_step pulses; abort kills the run at once.
module pong_match_ctrl_step_burst_gen (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  input  logic [3:0] len,
  output logic       ball_step
);

  logic [3:0] remain_q, remain_d;
  logic       step_q, step_d;

  // Load on start, count down one step per cycle; abort has priority.
  always_comb begin
    remain_d = remain_q;
    step_d   = 1'b0;
    if (abort) begin
      remain_d = 4'd0;
    end else if (start) begin
      remain_d = len - 4'd1;
      step_d   = 1'b1;
    end else if (remain_q != 4'd0) begin
      remain_d = remain_q - 4'd1;
      step_d   = 1'b1;
    end
  end

  // Step counter and registered step pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      remain_q <= 4'd0;
      step_q   <= 1'b0;
    end else begin
      remain_q <= remain_d;
      step_q   <= step_d;
    end
  end

  assign ball_step = step_q;

endmodule

// File: rtl/pong_match_ctrl.sv
// Match sequencer: match state, scores, serve timing, difficulty and step bursts.
module pong_match_ctrl
  import pong_match_ctrl_pkg::*;
#(
  parameter int WIN_SCORE    = 9,
  parameter int SERVE_FRAMES = 60,
  parameter int POINT_FRAMES = 30,
  parameter int MAX_LEVEL    = 15
) (
  input  logic               clk,
  input  logic               rst,
  pong_match_ctrl_if.slave   bus
);

  function automatic logic [3:0] sat_inc(input logic [3:0] v, input logic [3:0] lim);
    return (v >= lim) ? lim : v + 4'd1;
  endfunction

  state_t     state_q, state_d;
  state_t     origin_q, origin_d;
  logic [7:0] frame_cnt_q, frame_cnt_d;
  logic [3:0] scorep1_q, scorep1_d;
  logic [3:0] scorep2_q, scorep2_d;
  logic [3:0] difflevel_q, difflevel_d;
  logic       serve_q, serve_d;
  logic       serve_dir_q, serve_dir_d;
  logic       ball_visible_q, ball_visible_d;
  logic       paused_q, paused_d;
  logic       pause_btn_q;

  logic pause_edge, any_point, serve_done, point_done, win_reached, start_game;
  logic burst_start, burst_abort;

  assign pause_edge  = bus.pause_btn & ~pause_btn_q;
  assign any_point   = bus.point_p1 | bus.point_p2;
  assign serve_done  = bus.frame_tick && (frame_cnt_q == 8'(SERVE_FRAMES - 1));
  assign point_done  = bus.frame_tick && (frame_cnt_q == 8'(POINT_FRAMES - 1));
  assign win_reached = (scorep1_q == 4'(WIN_SCORE)) || (scorep2_q == 4'(WIN_SCORE));
  assign start_game  = ((state_q == ST_IDLE) || (state_q == ST_GAMEOVER)) && (state_d == ST_SERVE);

  // State register plus all match registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      origin_q       <= ST_SERVE;
      frame_cnt_q    <= 8'd0;
      scorep1_q      <= SCORE_HIDDEN;
      scorep2_q      <= SCORE_HIDDEN;
      difflevel_q    <= 4'd1;
      serve_q        <= 1'b0;
      serve_dir_q    <= 1'b1;
      ball_visible_q <= 1'b0;
      paused_q       <= 1'b0;
      pause_btn_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      origin_q       <= origin_d;
      frame_cnt_q    <= frame_cnt_d;
      scorep1_q      <= scorep1_d;
      scorep2_q      <= scorep2_d;
      difflevel_q    <= difflevel_d;
      serve_q        <= serve_d;
      serve_dir_q    <= serve_dir_d;
      ball_visible_q <= ball_visible_d;
      paused_q       <= paused_d;
      pause_btn_q    <= bus.pause_btn;
    end
  end

  // Next-state: a point beats a pause edge in PLAY; pause remembers where it came from.
  always_comb begin
    state_d  = state_q;
    origin_d = origin_q;
    case (state_q)
      ST_IDLE, ST_GAMEOVER: if (bus.frame_tick && bus.start_req) state_d = ST_SERVE;
      ST_SERVE: begin
        if (pause_edge) begin
          origin_d = ST_SERVE;
          state_d  = ST_PAUSE;
        end else if (serve_done) begin
          state_d = ST_PLAY;
        end
      end
      ST_PLAY: begin
        if (any_point) begin
          state_d = ST_POINT;
        end else if (pause_edge) begin
          origin_d = ST_PLAY;
          state_d  = ST_PAUSE;
        end
      end
      ST_POINT: if (point_done) state_d = win_reached ? ST_GAMEOVER : ST_SERVE;
      ST_PAUSE: if (pause_edge) state_d = origin_q;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Counters, scores and difficulty; frame count survives a trip through PAUSE.
  always_comb begin
    frame_cnt_d = frame_cnt_q;
    scorep1_d   = scorep1_q;
    scorep2_d   = scorep2_q;
    difflevel_d = difflevel_q;
    serve_dir_d = serve_dir_q;
    if (state_d != state_q) begin
      if ((state_q != ST_PAUSE) && (state_d != ST_PAUSE)) frame_cnt_d = 8'd0;
    end else if (bus.frame_tick && ((state_q == ST_SERVE) || (state_q == ST_POINT))) begin
      frame_cnt_d = frame_cnt_q + 8'd1;
    end
    if (start_game) begin
      scorep1_d   = 4'd0;
      scorep2_d   = 4'd0;
      difflevel_d = 4'd1;
      serve_dir_d = 1'b1;
    end else if (state_q == ST_PLAY) begin
      if (bus.point_p1) begin
        scorep1_d   = sat_inc(scorep1_q, 4'(WIN_SCORE));
        serve_dir_d = 1'b1;
        difflevel_d = 4'd1;
      end else if (bus.point_p2) begin
        scorep2_d   = sat_inc(scorep2_q, 4'(WIN_SCORE));
        serve_dir_d = 1'b0;
        difflevel_d = 4'd1;
      end else if (bus.stick_hit) begin
        difflevel_d = sat_inc(difflevel_q, 4'(MAX_LEVEL));
      end
    end
  end

  // Output decode from the state being entered, so outputs line up with the state.
  always_comb begin
    serve_d        = (state_d == ST_SERVE) && (state_q != ST_SERVE) && (state_q != ST_PAUSE);
    ball_visible_d = (state_d != ST_IDLE) && (state_d != ST_GAMEOVER);
    paused_d       = (state_d == ST_PAUSE);
    burst_start    = (state_q == ST_PLAY) && bus.frame_tick;
    burst_abort    = (state_q == ST_PLAY) && (any_point || pause_edge);
  end

  pong_match_ctrl_step_burst_gen u_burst (
    .clk       (clk),
    .rst       (rst),
    .start     (burst_start),
    .abort     (burst_abort),
    .len       (burst_len(difflevel_q)),
    .ball_step (bus.ball_step)
  );

  assign bus.scorep1      = scorep1_q;
  assign bus.scorep2      = scorep2_q;
  assign bus.difflevel    = difflevel_q;
  assign bus.serve        = serve_q;
  assign bus.serve_dir    = serve_dir_q;
  assign bus.ball_visible = ball_visible_q;
  assign bus.paused       = paused_q;

endmodule
